btn_step_gen: RTL and testbench

Debounced single-step clock generator for the board-level single-cycle CPU. It samples the raw push button in the free-running board clock domain, filters contact bounce, and emits exactly one fixed-width step clock per physical press. This clock drives the CPU clock input; the 7-segment display logic stays on the board clock. It also keeps a step counter for debug display.

---
 rtl/btn_step_gen_if.sv | 28 ++
 rtl/btn_step_gen.sv | 131 +++++++++++++
 tb/tb_btn_step_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/btn_step_gen_if.sv
// Button-to-step-clock signal bundle: raw button in, step clock, strobe,
// debounced level and press counter out.
interface btn_step_gen_if #(
  parameter int COUNT_W = 16
);
  logic               btn_raw;
  logic               step_clk;
  logic               step_pulse;
  logic               btn_level;
  logic [COUNT_W-1:0] step_count;

  // master drives the button; slave is the step generator.
  modport master (
    output btn_raw,
    input  step_clk,
    input  step_pulse,
    input  btn_level,
    input  step_count
  );

  modport slave (
    input  btn_raw,
    output step_clk,
    output step_pulse,
    output btn_level,
    output step_count
  );
endinterface

// File: rtl/btn_step_gen.sv
// Debounced single-step clock generator: one fixed-width step clock per
// accepted button press, plus debounced level and a wrapping press counter.
module btn_step_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int PULSE_CYCLES    = 4,
  parameter int COUNT_W         = 16
) (
  input  logic          base_clk,
  input  logic          reset,
  btn_step_gen_if.slave bus
);

  localparam int PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic               sync1_reg;
  logic               s_reg;
  state_t             state_reg,      state_next;
  logic [CNT_W-1:0]   cnt_reg,        cnt_next;
  logic [PCNT_W-1:0]  pcnt_reg,       pcnt_next;
  logic               step_clk_reg,   step_clk_next;
  logic               step_pulse_reg, step_pulse_next;
  logic               btn_level_reg,  btn_level_next;
  logic [COUNT_W-1:0] step_count_reg, step_count_next;
  logic               fire;

  // Debounce FSM: a level change is accepted only after N consecutive
  // samples of the opposite level; only the rising acceptance fires a step.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fire       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_reg) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          fire       = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s_reg) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s_reg) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = RELEASE_WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Step output stage; the pulse counter runs on its own once loaded.
  always_comb begin
    step_pulse_next = fire;
    step_clk_next   = fire || (pcnt_reg != '0);
    pcnt_next       = '0;
    if (fire) begin
      pcnt_next = PCNT_LOAD;
    end else if (pcnt_reg != '0) begin
      pcnt_next = pcnt_reg - PCNT_ONE;
    end
    step_count_next = fire ? (step_count_reg + COUNT_ONE) : step_count_reg;
    btn_level_next  = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

  always_ff @(posedge base_clk) begin
    if (reset) begin
      sync1_reg      <= 1'b1;
      s_reg          <= 1'b1;
      state_reg      <= RELEASE_WAIT;
      cnt_reg        <= '0;
      pcnt_reg       <= '0;
      step_clk_reg   <= 1'b0;
      step_pulse_reg <= 1'b0;
      btn_level_reg  <= 1'b1;
      step_count_reg <= '0;
    end else begin
      sync1_reg      <= bus.btn_raw;
      s_reg          <= sync1_reg;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pcnt_reg       <= pcnt_next;
      step_clk_reg   <= step_clk_next;
      step_pulse_reg <= step_pulse_next;
      btn_level_reg  <= btn_level_next;
      step_count_reg <= step_count_next;
    end
  end

  assign bus.step_clk   = step_clk_reg;
  assign bus.step_pulse = step_pulse_reg;
  assign bus.btn_level  = btn_level_reg;
  assign bus.step_count = step_count_reg;

endmodule

// File: tb/tb_btn_step_gen.sv
// Self-checking bench for btn_step_gen: directed vector table, scenario
// sequences and random button traffic against a run-length reference model.
module tb_btn_step_gen;
  localparam int N       = 4;
  localparam int CW      = 3;
  localparam int P       = 2;
  localparam int COUNT_W = 2;
  localparam int NVEC    = 22;

  logic clk = 1'b0;
  logic reset;

  btn_step_gen_if #(.COUNT_W(COUNT_W)) bus ();

  btn_step_gen #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W(CW),
    .PULSE_CYCLES(P),
    .COUNT_W(COUNT_W)
  ) dut (
    .base_clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       btn;
    bit       pulse;
    bit       sclk;
    bit       level;
    bit [1:0] count;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: debounced level flips after N consecutive opposite samples
  bit m_sync1, m_s, m_level, m_pulse;
  int m_run, m_since, m_count;

  // scenario observation
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int hi_len = 0;
  int count_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit rst, input bit b);
    bit fired;
    if (rst) begin
      m_sync1 = 1; m_s = 1; m_level = 1; m_run = 0;
      m_since = P; m_count = 0; m_pulse = 0;
    end else begin
      fired = 0;
      if (m_s != m_level) begin
        m_run++;
        if (m_run == N) begin
          m_level = m_s;
          m_run = 0;
          fired = m_s;
        end
      end else begin
        m_run = 0;
      end
      m_s = m_sync1;
      m_sync1 = b;
      m_pulse = fired;
      if (fired) begin
        m_since = 0;
        m_count = (m_count + 1) % (1 << COUNT_W);
      end else if (m_since < P) begin
        m_since++;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit b);
    reset = rst;
    bus.btn_raw = b;
    @(posedge clk);
    cyc++;
    model_edge(rst, b);
    #1;
    check("step_pulse", {31'd0, bus.step_pulse}, {31'd0, m_pulse});
    check("step_clk", {31'd0, bus.step_clk}, (m_since < P) ? 32'd1 : 32'd0);
    check("btn_level", {31'd0, bus.btn_level}, {31'd0, m_level});
    check("step_count", {30'd0, bus.step_count}, m_count);
    if (bus.step_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      count_q.push_back(int'(bus.step_count));
      $display("step at cycle %0d count %0d", cyc, bus.step_count);
    end
    if (bus.step_clk === 1'b1) begin
      hi_len++;
    end else begin
      if (hi_len > 0 && !rst) check("clk_width", hi_len, P);
      hi_len = 0;
    end
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, b);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    run(1'b0, 10);
    pulse_cnt = 0;
    count_q.delete();
  endtask

  vec_t tbl[NVEC];
  int rise_edge;

  initial begin
    reset = 1'b1;
    bus.btn_raw = 1'b0;

    // reset 5, release with button low, then clean press at edge 12
    tbl = '{
      '{1,0, 0,0,1,2'd0}, '{1,0, 0,0,1,2'd0}, '{1,0, 0,0,1,2'd0},
      '{1,0, 0,0,1,2'd0}, '{1,0, 0,0,1,2'd0},
      '{0,0, 0,0,1,2'd0}, '{0,0, 0,0,1,2'd0}, '{0,0, 0,0,1,2'd0},
      '{0,0, 0,0,1,2'd0}, '{0,0, 0,0,1,2'd0}, '{0,0, 0,0,0,2'd0},
      '{0,0, 0,0,0,2'd0},
      '{0,1, 0,0,0,2'd0}, '{0,1, 0,0,0,2'd0}, '{0,1, 0,0,0,2'd0},
      '{0,1, 0,0,0,2'd0}, '{0,1, 0,0,0,2'd0}, '{0,1, 1,1,1,2'd1},
      '{0,1, 0,1,1,2'd1}, '{0,1, 0,0,1,2'd1}, '{0,1, 0,0,1,2'd1},
      '{0,1, 0,0,1,2'd1}
    };

    for (int k = 0; k < NVEC; k++) begin
      cycle(tbl[k].rst, tbl[k].btn);
      check("tbl_pulse", {31'd0, bus.step_pulse}, {31'd0, tbl[k].pulse});
      check("tbl_clk", {31'd0, bus.step_clk}, {31'd0, tbl[k].sclk});
      check("tbl_level", {31'd0, bus.btn_level}, {31'd0, tbl[k].level});
      check("tbl_count", {30'd0, bus.step_count}, {30'd0, tbl[k].count});
    end
    run(1'b1, 10);

    // bounce 1,1,0 for 12 cycles, then steady high
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, (i % 3) != 2);
    check("bounce_no_pulse", pulse_cnt, 0);
    rise_edge = cyc + 1;
    run(1'b1, 15);
    check("bounce_pulses", pulse_cnt, 1);
    check("bounce_latency", last_pulse_cyc - rise_edge, N + 1);
    check("bounce_count", {30'd0, bus.step_count}, 1);

    // long hold with a 2-cycle glitch, genuine release, second press
    do_reset();
    run(1'b1, 50);
    run(1'b0, 2);
    run(1'b1, 48);
    check("glitch_level_held", {31'd0, bus.btn_level}, 1);
    check("glitch_one_pulse", pulse_cnt, 1);
    run(1'b0, 10);
    check("release_level", {31'd0, bus.btn_level}, 0);
    run(1'b1, 20);
    check("glitch_pulses", pulse_cnt, 2);
    check("glitch_count", {30'd0, bus.step_count}, 2);

    // reset while step_clk is high and the button is held
    do_reset();
    run(1'b1, N + 2);
    check("pre_reset_clk", {31'd0, bus.step_clk}, 1);
    cycle(1'b1, 1'b1);
    check("reset_clk", {31'd0, bus.step_clk}, 0);
    check("reset_count", {30'd0, bus.step_count}, 0);
    pulse_cnt = 0;
    run(1'b1, 20);
    check("held_after_reset", pulse_cnt, 0);
    run(1'b0, 10);
    run(1'b1, 20);
    check("press_after_reset", pulse_cnt, 1);

    // five presses wrap the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 10);
      run(1'b0, 10);
    end
    check("wrap_pulses", pulse_cnt, 5);
    if (count_q.size() == 5) begin
      check("wrap_seq0", count_q[0], 1);
      check("wrap_seq1", count_q[1], 2);
      check("wrap_seq2", count_q[2], 3);
      check("wrap_seq3", count_q[3], 0);
      check("wrap_seq4", count_q[4], 1);
    end

    // random bouncing traffic with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        cycle(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        run(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
